// File: rtl/cpu_fetch_queue_pkg.sv
// Shared CPU fetch types: queue entry layout, fetch state and instruction-class decode.
// Pure types/functions; no timing or flow control of its own.
package cpu_fetch_queue_pkg;

    localparam int TAG_WIDTH = 4;

    typedef logic [TAG_WIDTH-1:0] fetch_tag_t;

    typedef struct packed {
        fetch_tag_t  tag;
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_data_t;

    typedef enum logic {
        FETCH,
        WAIT_JUMP
    } fetch_state_t;

    typedef enum logic [2:0] {
        CLASS_OTHER,
        CLASS_JUMP,
        CLASS_JUMP_CONDITIONAL,
        CLASS_ECALL,
        CLASS_MRET,
        CLASS_WFI
    } instr_class_t;

    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [31:0] INSN_ECALL    = 32'h0000_0073;
    localparam logic [31:0] INSN_MRET     = 32'h3020_0073;
    localparam logic [31:0] INSN_WFI      = 32'h1050_0073;

    function automatic instr_class_t decode_class(input logic [31:0] insn);
        instr_class_t cls;
        cls = CLASS_OTHER;
        case (insn[6:0])
            OPCODE_JAL, OPCODE_JALR: cls = CLASS_JUMP;
            OPCODE_BRANCH:           cls = CLASS_JUMP_CONDITIONAL;
            default:                 cls = CLASS_OTHER;
        endcase
        if (insn == INSN_ECALL) cls = CLASS_ECALL;
        if (insn == INSN_MRET)  cls = CLASS_MRET;
        if (insn == INSN_WFI)   cls = CLASS_WFI;
        return cls;
    endfunction

    // Any non-sequential class leaves the next PC unknown until execute resolves it.
    function automatic logic ends_fetch_run(input instr_class_t cls);
        return cls != CLASS_OTHER;
    endfunction

endpackage

// File: rtl/cpu_fetch_queue_icache.sv
// Direct-mapped instruction cache, one word per line; hits return same cycle, misses forward bus data.
// No request while stalled or in reset; a miss waits on i_bus_ready.
module cpu_fetch_queue_icache #(
    parameter int LINES = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic [31:0] i_address,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata
);

    localparam int IDX_W = $clog2(LINES);

    logic [LINES-1:0] line_valid;
    logic [31:0]      line_addr [LINES];
    logic [31:0]      line_data [LINES];
    logic [IDX_W-1:0] index;
    logic             hit;
    logic             active;
    logic             fill;

    assign index         = i_address[IDX_W+1:2];
    assign hit           = line_valid[index] && (line_addr[index] == i_address);
    assign active        = !i_stall && !i_reset;
    assign o_bus_request = active && !hit;
    assign o_bus_address = i_address;
    assign o_ready       = active && (hit || i_bus_ready);
    assign o_rdata       = hit ? line_data[index] : i_bus_rdata;
    assign fill          = o_bus_request && i_bus_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            line_valid <= '0;
        end else if (fill) begin
            line_valid[index] <= 1'b1;
        end
    end

    // Contents are only trusted behind line_valid, so they need no reset.
    always_ff @(posedge i_clock) begin
        if (fill) begin
            line_addr[index] <= i_address;
            line_data[index] <= i_bus_rdata;
        end
    end

endmodule

// File: rtl/cpu_fetch_queue.sv
// Instruction fetch queue: fetches through the icache into a QUEUE_DEPTH entry buffer, halts on control flow, takes interrupts.
// Head is presented combinationally; fetch stalls when full or awaiting a jump, decode backpressures via i_ready.
module cpu_fetch_queue
    import cpu_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QUEUE_DEPTH  = 4
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_jump,
    input  logic [31:0]                        i_jump_pc,
    input  logic                               i_irq_pending,
    input  logic [31:0]                        i_irq_pc,
    output logic                               o_irq_dispatched,
    output logic [31:0]                        o_irq_epc,
    output logic                               o_bus_request,
    input  logic                               i_bus_ready,
    output logic [31:0]                        o_bus_address,
    input  logic [31:0]                        i_bus_rdata,
    output logic                               o_valid,
    input  logic                               i_ready,
    output fetch_data_t                        o_data,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_level
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int LEVEL_W = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      pc;
    fetch_tag_t       tag;
    fetch_tag_t       next_tag;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [LEVEL_W-1:0] level;
    fetch_data_t      entries [QUEUE_DEPTH];

    logic        full;
    logic        icache_stall;
    logic        icache_ready;
    logic [31:0] icache_rdata;
    logic        irq_take;
    logic        enqueue;
    logic        dequeue;
    logic        ends_run;

    assign full         = (level == LEVEL_W'(QUEUE_DEPTH));
    assign icache_stall = full || (state != FETCH);
    assign irq_take     = (state == FETCH) && i_irq_pending;
    assign o_valid      = (level != '0) && !irq_take;
    assign dequeue      = o_valid && i_ready;
    assign enqueue      = (state == FETCH) && icache_ready && !full && !irq_take;
    assign next_tag     = tag + fetch_tag_t'(1);
    assign ends_run     = ends_fetch_run(decode_class(icache_rdata));
    assign o_data       = entries[head_ptr];
    assign o_level      = level;

    cpu_fetch_queue_icache u_icache (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_stall       (icache_stall),
        .i_address     (pc),
        .o_ready       (icache_ready),
        .o_rdata       (icache_rdata),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (i_bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (i_bus_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state            <= FETCH;
            pc               <= RESET_VECTOR;
            tag              <= '0;
            o_irq_dispatched <= 1'b0;
            o_irq_epc        <= '0;
        end else begin
            o_irq_dispatched <= irq_take;
            // Return to the oldest unexecuted instruction, or to the next fetch if none is buffered.
            o_irq_epc        <= irq_take ? ((level != '0) ? o_data.pc : pc) : '0;
            if (irq_take) begin
                pc <= i_irq_pc;
            end else begin
                case (state)
                    FETCH: begin
                        if (enqueue) begin
                            tag <= next_tag;
                            if (ends_run) begin
                                state <= WAIT_JUMP;
                            end else begin
                                pc <= pc + 32'd4;
                            end
                        end
                    end
                    WAIT_JUMP: begin
                        if (i_jump) begin
                            pc    <= i_jump_pc;
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || irq_take) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            level    <= '0;
        end else begin
            if (enqueue) tail_ptr <= tail_ptr + PTR_W'(1);
            if (dequeue) head_ptr <= head_ptr + PTR_W'(1);
            case ({enqueue, dequeue})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (enqueue) begin
            entries[tail_ptr] <= '{tag: next_tag, instruction: icache_rdata, pc: pc};
        end
    end

endmodule
